// File: rtl/ysyx_210247_pipe_buf_pkg.sv
// Shared definitions for the elastic pipeline buffers between core stages.
// Holds the inter-stage bus widths that are used as WIDTH values.
// Optional build macro (left undefined here, so the default build has no
// stall counter): YSYX_210247_PIPE_BUF_STALL_CNT_EN adds the stall_cnt output.
package ysyx_210247_pipe_buf_pkg;

  localparam int PIPE_BUF_WIDTH_DEF = 64;

  // Stage-to-stage payload widths.
  localparam int IF_TO_ID_BUS  = 64;
  localparam int ID_TO_EX_BUS  = 128;
  localparam int EX_TO_MEM_BUS = 128;
  localparam int MEM_TO_WB_BUS = 96;

endpackage

// File: rtl/ysyx_210247_pipe_buf_ram.sv
// DEPTH x WIDTH register array for the pipeline buffer.
// Ports:
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address (asynchronous read)
//   rdata_o  - read data
// Storage is intentionally not reset; contents are only observed when the
// owning buffer reports a valid head entry.
module ysyx_210247_pipe_buf_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ysyx_210247_pipe_buf.sv
// Elastic pipeline buffer for inter-stage links: DEPTH-entry FIFO with a
// valid/allow handshake on both sides and synchronous flush.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   flush             - drop all entries (redirect/exception)
//   in_valid/in_data  - upstream payload, accepted when in_allow is high
//   in_allow          - buffer has room (registered state only)
//   out_valid/out_data- head entry
//   out_allow         - downstream consumes the head this cycle
//   occupancy         - entry count 0..DEPTH
//   stall_cnt         - only with YSYX_210247_PIPE_BUF_STALL_CNT_EN: cycles
//                       the head was held back by downstream, saturating
module ysyx_210247_pipe_buf
  import ysyx_210247_pipe_buf_pkg::*;
#(
  parameter  int WIDTH = PIPE_BUF_WIDTH_DEF,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_allow,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_allow,
  output logic [PTR_W:0]   occupancy
`ifdef YSYX_210247_PIPE_BUF_STALL_CNT_EN
  ,output logic [31:0]     stall_cnt
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;

  // in_allow depends on count only, so upstream allow never chains through
  // this stage combinationally. A full buffer refuses even when popping.
  assign in_allow  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign occupancy = count_q;

  assign push = in_valid & in_allow;
  assign pop  = out_valid & out_allow;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A push in a flush/reset cycle is discarded, so it must not touch storage.
  ysyx_210247_pipe_buf_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (push & ~flush & ~rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

`ifdef YSYX_210247_PIPE_BUF_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts downstream back-pressure; survives flush so it reflects the
  // whole run since reset.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid & ~out_allow & ~flush & (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
